data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter ADDR_W, default 8, address width in bits.
REQ-002 Parameter DATA_W, default 16, data word width in bits.
REQ-003 Parameter DEPTH, default 2**ADDR_W (256), number of words.
REQ-004 clk  input  1  single clock; all writes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 MemWrite  input  1  write enable, sampled at rising clk.
REQ-007 MemRead  input  1  read enable; gates the read data output.
REQ-008 address  input  ADDR_W  word address for both read and write.
REQ-009 WriteData_dmem  input  DATA_W  write data word.
REQ-010 ReadData_dmem  output  DATA_W  read data word.

Function
REQ-011 The block SHALL hold DEPTH words of DATA_W bits, word-addressed, with no byte enables.
REQ-012 On a rising clk edge with MemWrite=1 and reset=0, mem[address] SHALL take WriteData_dmem. Write latency is 1 edge.
REQ-013 ReadData_dmem SHALL be combinational: mem[address] when MemRead=1, else all zeros. Read latency is 0 cycles.
REQ-014 With MemWrite=1 and MemRead=1 at the same address, ReadData_dmem SHALL show the pre-edge contents until the edge, then the new word (default, without the macro).
REQ-015 With MemWrite=0, memory contents SHALL be unchanged regardless of MemRead or address activity.
REQ-016 Every address 0..DEPTH-1 SHALL be valid. With DEPTH equal to 2**ADDR_W there is no out-of-range address.
REQ-017 An X or Z on MemWrite SHALL NOT corrupt memory in simulation. The write is treated as not enabled.

Reset
REQ-018 While reset=1, all DEPTH words SHALL be cleared to 0 asynchronously, and writes SHALL be ignored.
REQ-019 While reset=1, ReadData_dmem SHALL be 0 (MemRead=1 reads a cleared word).
REQ-020 Deasserting reset mid-operation SHALL resume normal writes from the first rising clk after deassertion.

Configuration
REQ-021 Macro DATA_MEM_WRITE_FWD_EN enables write-through forwarding.
- Defined: when MemRead=1, MemWrite=1 and reset=0, ReadData_dmem SHALL equal WriteData_dmem combinationally, in the same cycle.
- Not defined: REQ-014 applies.

Structure
REQ-022 Package data_mem_pkg SHALL hold ADDR_W/DATA_W defaults and the data and address word typedefs.
REQ-023 The storage array SHALL be a sub-module, data_mem_array, holding the async-clear register file. data_mem adds the read gating and the forwarding logic.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset: pulse reset, then MemRead=1 at address 0, 7 and 255 -> ReadData_dmem=0x0000 for each.
- Write then read: MemWrite=1, address=7, WriteData_dmem=0x0011 for one edge; then MemWrite=0, MemRead=1, address=7 -> ReadData_dmem=0x0011.
- Read gating: after the write above, MemRead=0, address=7 -> ReadData_dmem=0x0000.
- Boundary and isolation: write 0xFFFF at 255 and 0xA5A5 at 0 -> reads return 0xFFFF and 0xA5A5; address 7 still returns 0x0011.
- Simultaneous read/write: address 7 holds 0x0011; write 0x2222 with MemRead=1 -> 0x0011 before the edge and 0x2222 after; with DATA_MEM_WRITE_FWD_EN defined -> 0x2222 immediately.
- Async reset mid-run: assert reset between clock edges -> ReadData_dmem=0 at once; a write attempted during reset is lost.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared widths and word types for the data memory.
package data_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/data_mem_array.sv
// Word-addressed register file with asynchronous clear of every word.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // An X/Z write enable takes the else path of the if, so no write happens.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i == 1'b1) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem.sv
// Data memory: async-clear storage, combinational gated read.
// Define DATA_MEM_WRITE_FWD_EN to forward write data onto a same-cycle read.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] WriteData_dmem,
    output logic [DATA_W-1:0] ReadData_dmem
);

    logic [DATA_W-1:0] array_rdata;
    logic [DATA_W-1:0] read_word;

    data_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (reset),
        .we_i    (MemWrite),
        .addr_i  (address),
        .wdata_i (WriteData_dmem),
        .rdata_o (array_rdata)
    );

`ifdef DATA_MEM_WRITE_FWD_EN
    // The word about to be written wins over the stored one.
    assign read_word = (MemWrite && !reset) ? WriteData_dmem : array_rdata;
`else
    assign read_word = array_rdata;
`endif

    assign ReadData_dmem = MemRead ? read_word : '0;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus random traffic
// checked against an array model of the memory.
module tb_data_mem;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic        MemRead;
    logic [7:0]  address;
    logic [15:0] WriteData_dmem;
    logic [15:0] ReadData_dmem;

    logic [15:0] model_mem [256];
    int          total;
    int          bad;

    data_mem dut (
        .clk            (clk),
        .reset          (reset),
        .MemWrite       (MemWrite),
        .MemRead        (MemRead),
        .address        (address),
        .WriteData_dmem (WriteData_dmem),
        .ReadData_dmem  (ReadData_dmem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_read(input logic rd, input logic we,
                                             input logic [7:0] a, input logic [15:0] wd);
        logic [15:0] r;
        if (!rd) return 16'h0000;
        r = model_mem[a];
`ifdef DATA_MEM_WRITE_FWD_EN
        if (we) r = wd;
`else
        if (we) r = model_mem[a];
`endif
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 16'h0000;
    endtask

    task automatic do_read(input string tag, input logic rd, input logic [7:0] a);
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = rd;
        address  = a;
        #1;
        check(tag, ReadData_dmem, exp_read(rd, 1'b0, a, 16'h0000));
    endtask

    // One write edge; the read port is checked just before and just after it.
    task automatic do_write(input string tag, input logic [7:0] a, input logic [15:0] d,
                            input logic rd);
        @(negedge clk);
        MemWrite       = 1'b1;
        MemRead        = rd;
        address        = a;
        WriteData_dmem = d;
        #1;
        check({tag, "_pre"}, ReadData_dmem, exp_read(rd, 1'b1, a, d));
        @(posedge clk);
        model_mem[a] = d;
        #1;
        check({tag, "_post"}, ReadData_dmem, rd ? d : 16'h0000);
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        address  = 8'h00;
        WriteData_dmem = 16'h0000;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // reset state
        do_read("rst_a0", 1'b1, 8'd0);
        do_read("rst_a7", 1'b1, 8'd7);
        do_read("rst_a255", 1'b1, 8'd255);
        check("rst_a255_const", ReadData_dmem, 16'h0000);

        // write then read, read gating
        do_write("wr7", 8'd7, 16'h0011, 1'b0);
        do_read("rd7", 1'b1, 8'd7);
        check("rd7_const", ReadData_dmem, 16'h0011);
        do_read("gate7", 1'b0, 8'd7);
        check("gate7_const", ReadData_dmem, 16'h0000);

        // boundaries and isolation
        do_write("wr255", 8'd255, 16'hFFFF, 1'b0);
        do_write("wr0", 8'd0, 16'hA5A5, 1'b0);
        do_read("rd255", 1'b1, 8'd255);
        check("rd255_const", ReadData_dmem, 16'hFFFF);
        do_read("rd0", 1'b1, 8'd0);
        check("rd0_const", ReadData_dmem, 16'hA5A5);
        do_read("rd7_iso", 1'b1, 8'd7);
        check("rd7_iso_const", ReadData_dmem, 16'h0011);

        // simultaneous read and write at the same address
        @(negedge clk);
        MemWrite = 1'b1;
        MemRead  = 1'b1;
        address  = 8'd7;
        WriteData_dmem = 16'h2222;
        #1;
`ifdef DATA_MEM_WRITE_FWD_EN
        check("rw_pre_fwd", ReadData_dmem, 16'h2222);
`else
        check("rw_pre", ReadData_dmem, 16'h0011);
`endif
        @(posedge clk);
        model_mem[7] = 16'h2222;
        #1;
        check("rw_post", ReadData_dmem, 16'h2222);

        // unknown write enable must not write
        @(negedge clk);
        MemWrite = 1'bx;
        MemRead  = 1'b0;
        address  = 8'd7;
        WriteData_dmem = 16'hDEAD;
        @(posedge clk);
        do_read("x_we", 1'b1, 8'd7);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic        we, rd;
            logic [7:0]  a;
            logic [15:0] d;
            we = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 1)) ? 255 : 0)
                                             : 8'($urandom_range(0, 255));
            d  = 16'($urandom);
            @(negedge clk);
            MemWrite = we;
            MemRead  = rd;
            address  = a;
            WriteData_dmem = d;
            #1;
            check("rand_rd", ReadData_dmem, exp_read(rd, we, a, d));
            @(posedge clk);
            if (we) model_mem[a] = d;
        end
        @(negedge clk);
        MemWrite = 1'b0;

        // async reset between edges, write during reset is lost
        MemRead = 1'b1;
        address = 8'd7;
        #1;
        check("pre_mid_rst", ReadData_dmem, model_mem[7]);
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        check("mid_rst_rd", ReadData_dmem, 16'h0000);
        MemWrite = 1'b1;
        address  = 8'd3;
        WriteData_dmem = 16'h1234;
        @(posedge clk);
        #1;
        check("rst_wr_rd", ReadData_dmem, 16'h0000);
        @(negedge clk);
        MemWrite = 1'b0;
        reset    = 1'b0;
        do_read("rst_lost3", 1'b1, 8'd3);
        do_read("rst_clr7", 1'b1, 8'd7);
        do_write("post_rst_wr", 8'd5, 16'hBEEF, 1'b1);

        // full sweep against the model
        for (int i = 0; i < 256; i++) begin
            do_read("sweep", 1'b1, 8'(i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
